// File: rtl/feature_frame_packer.sv
// Beat-to-frame packer: assembles NUM_CHANNEL features from LANES-wide beats, double-buffered output.
// Optional saturating error counter with synchronous clear when FEATURE_PACKER_ERR_CNT_EN is defined.
//
// state | meaning
// FILL  | accepting beats into the assembly register
// FULL  | frame complete, waiting for the output register to free up
// DRAIN | malformed frame, dropping beats up to and including sin_last
module feature_frame_packer #(
   parameter int NUM_CHANNEL   = 214,
   parameter int CHANNEL_WIDTH = 2,
   parameter int LANES         = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
`ifdef FEATURE_PACKER_ERR_CNT_EN
   input  logic                                 err_count_clr,
   output logic [15:0]                          err_count,
`endif
   input  logic                                 sin_valid,
   output logic                                 sin_ready,
   input  logic [LANES*CHANNEL_WIDTH-1:0]       sin_data,
   input  logic                                 sin_last,
   output logic                                 fin_valid,
   input  logic                                 fin_ready,
   output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
   output logic                                 frame_err
);

   localparam int BEATS = (NUM_CHANNEL + LANES - 1) / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int FW    = NUM_CHANNEL * CHANNEL_WIDTH;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {S_FILL, S_FULL, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FW-1:0]    asm_q, asm_d;
   logic             accept;
   logic             out_free;
   logic             err_d;
   logic             load_new;
   logic             load_held;

   assign sin_ready = (state_q != S_FULL);
   assign accept    = sin_valid && sin_ready;
   assign out_free  = !fin_valid || fin_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      load_new  = 1'b0;
      load_held = 1'b0;
      case (state_q)
         S_FILL: begin
            if (accept) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d = '0;
                  if (!sin_last) begin
                     err_d   = 1'b1;
                     state_d = S_DRAIN;
                  end else if (out_free) begin
                     load_new = 1'b1;
                  end else begin
                     state_d = S_FULL;
                  end
               end else if (sin_last) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_FULL: begin
            if (out_free) begin
               load_held = 1'b1;
               state_d   = S_FILL;
            end
         end
         S_DRAIN: begin
            if (accept && sin_last) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   // Merge the current beat so a completing frame can go straight to the output register.
   always_comb begin
      int ch;
      ch    = 0;
      asm_d = asm_q;
      if (accept && (state_q == S_FILL)) begin
         for (int j = 0; j < LANES; j++) begin
            ch = int'(cnt_q) * LANES + j;
            if (ch < NUM_CHANNEL)
               asm_d[(NUM_CHANNEL-1-ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                  sin_data[(LANES-1-j)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FILL;
         cnt_q        <= '0;
         asm_q        <= '0;
         features_top <= '0;
         fin_valid    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         frame_err <= err_d;
         if (load_new) begin
            features_top <= asm_d;
            fin_valid    <= 1'b1;
         end else if (load_held) begin
            features_top <= asm_q;
            fin_valid    <= 1'b1;
         end else if (fin_ready) begin
            fin_valid <= 1'b0;
         end
      end
   end

`ifdef FEATURE_PACKER_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || err_count_clr)
         err_count <= '0;
      else if (frame_err && (err_count != 16'hFFFF))
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
